aes_core_arbiter: RTL and testbench

- Two-requester scheduler that shares one AES_top encryption core.
- Accepts plaintext/key jobs over valid/ready handshakes and grants the core round-robin.
- Holds the core enable and operands stable for the whole encryption, then returns the ciphertext tagged with the requester ID.
- A timeout guard keeps the arbiter from hanging if the core never asserts its output-valid.

---
 rtl/aes_core_arbiter.sv | 123 ++++++++++++
 tb/tb_aes_core_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Round-robin scheduler that time-shares one AES core between two requesters,
// with a timeout guard on the core's output-valid and a sticky stray-valid flag.
module aes_core_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 7
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         err_stray,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             rr_last;
  logic             grant;
  logic             accept;

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; valid must hold with stable payload until then, ready may depend
  // combinationally on valid.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~rr_last;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign state_dbg  = state;

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state        <= IDLE;
      counter      <= '0;
      rr_last      <= 1'b1;
      core_en      <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      // Output-valid outside RUN is flagged and otherwise ignored.
      if (core_data_out_valid && state != RUN) err_stray <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            core_data_in <= grant ? req1_data : req0_data;
            core_key_in  <= grant ? req1_key : req0_key;
            rsp_id       <= grant;
            rr_last      <= grant;
            counter      <= '0;
            core_en      <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (core_data_out_valid) begin
            rsp_data    <= core_data_out;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            core_en     <= 1'b0;
            state       <= RESP;
          end else if (counter == TIMEOUT_LAST) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            core_en     <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            counter   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          // Enable stays low long enough for the core's round counter to re-arm.
          counter <= counter + 1'b1;
          if (counter == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter: behavioural core stand-in, transaction
// level reference model with an expected-response queue, directed scenarios.
module tb_aes_core_arbiter;

  localparam int TIMEOUT    = 64;
  localparam int GAP_CYCLES = 2;
  localparam int CNT_W      = 7;

  logic         AES_clk;
  logic         AES_rst;
  logic         req0_valid, req0_ready;
  logic [127:0] req0_data, req0_key;
  logic         req1_valid, req1_ready;
  logic [127:0] req1_data, req1_key;
  logic         core_en;
  logic [127:0] core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_timeout, err_stray;
  logic [127:0] rsp_data;
  logic [1:0]   state_dbg;

  aes_core_arbiter #(
    .TIMEOUT(TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .AES_clk(AES_clk),
    .AES_rst(AES_rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_data(req0_data),
    .req0_key(req0_key),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_data(req1_data),
    .req1_key(req1_key),
    .core_en(core_en),
    .core_data_in(core_data_in),
    .core_key_in(core_key_in),
    .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .err_stray(err_stray),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge AES_clk);
    #1;
  endtask

  // Stand-in for the encryption: any fixed mixing of plaintext and key will do.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  // ---------------- core model ----------------
  int  lat_force     = 0;
  bit  withhold_next = 0;
  bit  stray_req     = 0;
  int  core_cnt      = 0;
  int  core_lat      = 1;
  bit  core_hold     = 0;

  always @(posedge AES_clk) begin
    #1;
    if (core_en) begin
      if (core_cnt == 0) begin
        core_lat      = (lat_force != 0) ? lat_force : $urandom_range(1, 12);
        core_hold     = withhold_next;
        withhold_next = 0;
      end
      core_cnt++;
      core_data_out_valid = !core_hold && (core_cnt == core_lat);
      core_data_out = core_data_out_valid ? core_fn(core_data_in, core_key_in)
                                          : {$urandom, $urandom, $urandom, $urandom};
    end else begin
      core_cnt            = 0;
      core_data_out_valid = stray_req;
      core_data_out       = {$urandom, $urandom, $urandom, $urandom};
      stray_req           = 0;
    end
  end

  // ---------------- response consumer ----------------
  int rsp_mode = 1;  // 0 random, 1 always ready, 2 stalled
  always @(posedge AES_clk) begin
    #1;
    case (rsp_mode)
      0:       rsp_ready = 1'($urandom_range(0, 1));
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  logic [129:0] exp_q[$];          // {id, timeout, data}
  int           dut_grants[$];
  bit           busy, run_flag, exp_stray, last_w;
  int           gap_left, run_cnt;
  logic         cur_id;
  logic [127:0] cur_data, cur_key;
  bit           e0, e1;

  always @(negedge AES_clk) begin
    if (AES_rst) begin
      check("rst_core_en", 128'(core_en), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_rsp_data", rsp_data, 128'(0));
      check("rst_rsp_id", 128'(rsp_id), 128'(0));
      check("rst_rsp_timeout", 128'(rsp_timeout), 128'(0));
      check("rst_err_stray", 128'(err_stray), 128'(0));
      check("rst_core_data_in", core_data_in, 128'(0));
      check("rst_core_key_in", core_key_in, 128'(0));
      exp_q.delete();
      dut_grants.delete();
      busy = 0; run_flag = 0; exp_stray = 0; last_w = 1;
      gap_left = 0; run_cnt = 0;
    end else begin
      e0 = !busy && req0_valid && (!req1_valid || last_w);
      e1 = !busy && req1_valid && (!req0_valid || !last_w);
      check("req0_ready", 128'(req0_ready), 128'(e0));
      check("req1_ready", 128'(req1_ready), 128'(e1));
      check("core_en", 128'(core_en), 128'(run_flag));
      if (run_flag) begin
        check("core_data_in_hold", core_data_in, cur_data);
        check("core_key_in_hold", core_key_in, cur_key);
      end
      check("err_stray", 128'(err_stray), 128'(exp_stray));
      check("rsp_valid", 128'(rsp_valid), 128'(exp_q.size() != 0));
      if (rsp_valid && exp_q.size() != 0) begin
        check("rsp_id", 128'(rsp_id), 128'(exp_q[0][129]));
        check("rsp_timeout", 128'(rsp_timeout), 128'(exp_q[0][128]));
        check("rsp_data", rsp_data, exp_q[0][127:0]);
      end
      if (req0_valid && req0_ready) dut_grants.push_back(0);
      if (req1_valid && req1_ready) dut_grants.push_back(1);

      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) busy = 0;
      end
      if (run_flag) begin
        run_cnt++;
        if (core_data_out_valid) begin
          exp_q.push_back({cur_id, 1'b0, core_fn(cur_data, cur_key)});
          run_flag = 0;
        end else if (run_cnt == TIMEOUT) begin
          exp_q.push_back({cur_id, 1'b1, 128'd0});
          run_flag = 0;
        end
      end else if (core_data_out_valid) begin
        exp_stray = 1;
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        gap_left = GAP_CYCLES;
      end
      if (e0 || e1) begin
        cur_id   = e1;
        cur_data = e1 ? req1_data : req0_data;
        cur_key  = e1 ? req1_key : req0_key;
        last_w   = e1;
        busy     = 1;
        run_flag = 1;
        run_cnt  = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_req(input int n, input logic v, input logic [127:0] d, input logic [127:0] k);
    if (n == 0) begin
      req0_valid = v; req0_data = d; req0_key = k;
    end else begin
      req1_valid = v; req1_data = d; req1_key = k;
    end
  endtask

  task automatic drive_req(input int n, input int jobs, input int max_gap,
                           input bit use_fixed, input logic [127:0] fd, input logic [127:0] fk);
    logic [127:0] d, k;
    bit done;
    for (int j = 0; j < jobs; j++) begin
      repeat ($urandom_range(0, max_gap)) step();
      d = use_fixed ? fd : {$urandom, $urandom, $urandom, $urandom};
      k = use_fixed ? fk : {$urandom, $urandom, $urandom, $urandom};
      set_req(n, 1'b1, d, k);
      done = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(negedge AES_clk);
        if (!AES_rst && ((n == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)))
          done = 1;
        step();
      end
      if (!done) check("handshake_bound", 128'(0), 128'(1));
      set_req(n, 1'b0, d, k);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      step();
      if (exp_q.size() == 0 && !busy && !run_flag) ok = 1;
    end
    if (!ok) check("idle_bound", 128'(0), 128'(1));
  endtask

  // ---------------- sequence ----------------
  initial begin
    AES_rst = 1'b1;
    req0_valid = 0; req0_data = '0; req0_key = '0;
    req1_valid = 0; req1_data = '0; req1_key = '0;
    core_data_out = '0; core_data_out_valid = 0; rsp_ready = 0;
    repeat (3) step();
    AES_rst = 1'b0;

    // single directed req0 job
    rsp_mode  = 1;
    lat_force = 10;
    drive_req(0, 1, 0, 1, 128'h00000021_00000000_00000000_00000000,
              128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    wait_idle();
    check("directed_grants", 128'(dut_grants.size()), 128'(1));
    lat_force = 0;

    // timeout then a normal job
    rsp_mode = 0;
    withhold_next = 1;
    drive_req(1, 1, 0, 0, '0, '0);
    wait_idle();
    drive_req(0, 1, 0, 0, '0, '0);
    wait_idle();

    // long response backpressure with a second job waiting
    rsp_mode = 2;
    fork
      drive_req(0, 1, 0, 0, '0, '0);
      drive_req(1, 1, 0, 0, '0, '0);
      begin
        for (int c = 0; c < 200 && !rsp_valid; c++) step();
        check("bp_rsp_seen", 128'(rsp_valid), 128'(1));
        repeat (20) step();
        rsp_mode = 1;
      end
    join
    wait_idle();

    // reset in the middle of RUN, then both requesters contend
    lat_force = 40;
    drive_req(0, 1, 0, 0, '0, '0);
    for (int c = 0; c < 50 && !core_en; c++) step();
    lat_force = 0;
    repeat (10) step();
    #2;
    AES_rst = 1'b1;
    #1;
    check("async_core_en", 128'(core_en), 128'(0));
    check("async_rsp_valid", 128'(rsp_valid), 128'(0));
    fork
      drive_req(0, 2, 0, 0, '0, '0);
      drive_req(1, 2, 0, 0, '0, '0);
      begin
        step();
        step();
        AES_rst = 1'b0;
      end
    join
    wait_idle();
    check("fair_count", 128'(dut_grants.size()), 128'(4));
    for (int i = 0; i < dut_grants.size() && i < 4; i++)
      check("fair_order", 128'(dut_grants[i]), 128'(i % 2));

    // stray output-valid while idle
    stray_req = 1;
    repeat (4) step();
    check("stray_sticky", 128'(err_stray), 128'(1));

    // random traffic
    rsp_mode = 0;
    fork
      drive_req(0, 6, 4, 0, '0, '0);
      drive_req(1, 6, 4, 0, '0, '0);
    join
    wait_idle();
    check("stray_still_set", 128'(err_stray), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
